// File: rtl/ins_decoder.sv
// Instruction decoder: dispatches load/save commands, tracks outstanding transfers, handles barriers and config.
// Optional macro INS_OPCODE_CHECK_EN: drop load/save instructions with illegal opcodes and raise sticky err.
module ins_decoder #(
  parameter int unsigned CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] ins,
  input  logic        ins_valid,
  output logic        ins_ready,
  output logic [3:0]  layer_type,
  output logic [3:0]  in_seg,
  output logic [3:0]  out_seg,
  output logic [7:0]  in_width,
  output logic [7:0]  out_width,
  output logic        cfg_valid,
  output logic [3:0]  rd_op,
  output logic [5:0]  rd_buf_id,
  output logic [7:0]  rd_size,
  output logic [31:0] rd_addr,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [3:0]  wr_op,
  output logic [5:0]  wr_buf_id,
  output logic [7:0]  wr_size,
  output logic [31:0] wr_addr,
  output logic        wr_valid,
  input  logic        wr_ready,
  input  logic        rd_done,
  input  logic        wr_done,
  output logic        sync_done,
  output logic        err
);

  localparam logic [1:0] T_LOAD = 2'b00;
  localparam logic [1:0] T_SAVE = 2'b01;
  localparam logic [1:0] T_BAR  = 2'b10;
  localparam logic [1:0] T_CFG  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RD, WR, SYNC} state_t;

  state_t           state;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_nxt;
  logic [CNT_W-1:0] wr_cnt, wr_cnt_nxt;
  logic             ins_fire, rd_fire, wr_fire, op_ok;
  logic [1:0]       ins_type;
  logic [3:0]       ins_op;

  assign ins_type = ins[63:62];
  assign ins_op   = ins[61:58];
  assign ins_fire = ins_valid && ins_ready;
  assign rd_fire  = rd_valid && rd_ready;
  assign wr_fire  = wr_valid && wr_ready;

  // Outstanding counters; a simultaneous issue and completion cancel out, completions at zero are ignored.
  always_comb begin
    rd_cnt_nxt = rd_cnt;
    wr_cnt_nxt = wr_cnt;
    if (rd_fire && !rd_done)
      rd_cnt_nxt = rd_cnt + CNT_W'(1);
    else if (!rd_fire && rd_done && rd_cnt != '0)
      rd_cnt_nxt = rd_cnt - CNT_W'(1);
    if (wr_fire && !wr_done)
      wr_cnt_nxt = wr_cnt + CNT_W'(1);
    else if (!wr_fire && wr_done && wr_cnt != '0)
      wr_cnt_nxt = wr_cnt - CNT_W'(1);
  end

`ifdef INS_OPCODE_CHECK_EN
  always_comb begin
    op_ok = 1'b1;
    if (ins_type == T_LOAD) begin
      case (ins_op)
        4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: op_ok = 1'b1;
        default:                                  op_ok = 1'b0;
      endcase
    end else if (ins_type == T_SAVE) begin
      case (ins_op)
        4'h0, 4'h2, 4'h3, 4'h4, 4'h5: op_ok = 1'b1;
        default:                      op_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (ins_fire && !op_ok)
      err <= 1'b1;
  end
`else
  assign op_ok = 1'b1;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      ins_ready  <= 1'b0;
      cfg_valid  <= 1'b0;
      sync_done  <= 1'b0;
      layer_type <= '0;
      in_seg     <= '0;
      out_seg    <= '0;
      in_width   <= '0;
      out_width  <= '0;
      rd_valid   <= 1'b0;
      rd_op      <= '0;
      rd_buf_id  <= '0;
      rd_size    <= '0;
      rd_addr    <= '0;
      wr_valid   <= 1'b0;
      wr_op      <= '0;
      wr_buf_id  <= '0;
      wr_size    <= '0;
      wr_addr    <= '0;
    end else begin
      rd_cnt    <= rd_cnt_nxt;
      wr_cnt    <= wr_cnt_nxt;
      cfg_valid <= 1'b0;
      sync_done <= 1'b0;
      case (state)
        IDLE: begin
          ins_ready <= 1'b1;
          if (ins_fire && op_ok) begin
            case (ins_type)
              T_LOAD: begin
                state     <= RD;
                ins_ready <= 1'b0;
                rd_op     <= ins[61:58];
                rd_buf_id <= ins[57:52];
                rd_size   <= ins[39:32];
                rd_addr   <= ins[31:0];
                rd_valid  <= (rd_cnt_nxt != CNT_MAX);
              end
              T_SAVE: begin
                state     <= WR;
                ins_ready <= 1'b0;
                wr_op     <= ins[61:58];
                wr_buf_id <= ins[57:52];
                wr_size   <= ins[39:32];
                wr_addr   <= ins[31:0];
                wr_valid  <= (wr_cnt_nxt != CNT_MAX);
              end
              T_BAR: begin
                state     <= SYNC;
                ins_ready <= 1'b0;
              end
              T_CFG: begin
                layer_type <= ins[61:58];
                in_seg     <= ins[55:52];
                out_seg    <= ins[51:48];
                in_width   <= ins[47:40];
                out_width  <= ins[39:32];
                cfg_valid  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RD: begin
          if (rd_fire) begin
            state     <= IDLE;
            rd_valid  <= 1'b0;
            ins_ready <= 1'b1;
          end else begin
            rd_valid <= (rd_cnt_nxt != CNT_MAX);
          end
        end
        WR: begin
          if (wr_fire) begin
            state     <= IDLE;
            wr_valid  <= 1'b0;
            ins_ready <= 1'b1;
          end else begin
            wr_valid <= (wr_cnt_nxt != CNT_MAX);
          end
        end
        SYNC: begin
          // Leave on the cycle both counters have drained, flagging it with sync_done.
          if (rd_cnt_nxt == '0 && wr_cnt_nxt == '0) begin
            state     <= IDLE;
            sync_done <= 1'b1;
            ins_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_decoder.sv
// Directed self-checking bench for ins_decoder (CNT_W = 4).
module tb_ins_decoder;

  localparam int unsigned CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] ins;
  logic        ins_valid, ins_ready;
  logic [3:0]  layer_type, in_seg, out_seg;
  logic [7:0]  in_width, out_width;
  logic        cfg_valid;
  logic [3:0]  rd_op, wr_op;
  logic [5:0]  rd_buf_id, wr_buf_id;
  logic [7:0]  rd_size, wr_size;
  logic [31:0] rd_addr, wr_addr;
  logic        rd_valid, rd_ready, wr_valid, wr_ready;
  logic        rd_done, wr_done, sync_done, err;

  int checks = 0;
  int errors = 0;

  ins_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .layer_type(layer_type), .in_seg(in_seg), .out_seg(out_seg),
    .in_width(in_width), .out_width(out_width), .cfg_valid(cfg_valid),
    .rd_op(rd_op), .rd_buf_id(rd_buf_id), .rd_size(rd_size), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_op(wr_op), .wr_buf_id(wr_buf_id), .wr_size(wr_size), .wr_addr(wr_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_done(rd_done), .wr_done(wr_done),
    .sync_done(sync_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_xfer(input logic [1:0] t, input logic [3:0] op,
                                          input logic [5:0] id, input logic [7:0] sz,
                                          input logic [31:0] a);
    return {t, op, id, 12'h000, sz, a};
  endfunction

  // Present one instruction and hold it exactly for its accepting edge.
  task automatic send(input logic [63:0] w);
    int n = 0;
    while (!ins_ready && n < 64) begin
      tick();
      n++;
    end
    check("ins_ready_wait", ins_ready, 1'b1);
    ins       = w;
    ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
  endtask

  // Load with rd_ready already high: command visible next cycle, handshakes on that edge.
  task automatic load_hs(input logic [3:0] op);
    send(mk_xfer(2'b00, op, 6'd1, 8'h08, 32'h0000_1000));
    check("ld_valid", rd_valid, 1'b1);
    tick();
  endtask

  task automatic done_rd(input int n);
    rd_done = 1'b1;
    repeat (n) tick();
    rd_done = 1'b0;
  endtask

  localparam logic [63:0] CFG_A = 64'hC012_1C0E_0000_0000;
  localparam logic [63:0] CFG_B = 64'hC434_0A05_0000_0000;
  localparam logic [63:0] BAR   = 64'h8000_0000_0000_0000;

  initial begin
    rst_n = 1'b0; ins = '0; ins_valid = 1'b0;
    rd_ready = 1'b0; wr_ready = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
    tick(); tick();
    check("rst_ins_ready", ins_ready, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_cfg_valid", cfg_valid, 1'b0);
    check("rst_sync_done", sync_done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cfg", {layer_type, in_seg, out_seg, in_width, out_width}, 28'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", ins_ready, 1'b1);

    // Back-to-back config words, one per cycle.
    ins = CFG_A; ins_valid = 1'b1;
    tick();
    ins = CFG_B;
    check("cfg_a_valid", cfg_valid, 1'b1);
    check("cfg_a_fields", {layer_type, in_seg, out_seg, in_width, out_width}, {4'h0, 4'h1, 4'h2, 8'd28, 8'd14});
    check("cfg_a_ready", ins_ready, 1'b1);
    tick();
    ins_valid = 1'b0;
    check("cfg_b_valid", cfg_valid, 1'b1);
    check("cfg_b_fields", {layer_type, in_seg, out_seg, in_width, out_width}, {4'h1, 4'h3, 4'h4, 8'd10, 8'd5});
    tick();
    check("cfg_pulse_end", cfg_valid, 1'b0);

    // Load stalled by rd_ready low for three cycles.
    send(mk_xfer(2'b00, 4'b0100, 6'd5, 8'h40, 32'h0010_0000));
    for (int i = 0; i < 3; i++) begin
      check("ld_stall_valid", rd_valid, 1'b1);
      check("ld_stall_fields", {rd_op, rd_buf_id, rd_size, rd_addr}, {4'h4, 6'd5, 8'h40, 32'h0010_0000});
      check("ld_stall_ready", ins_ready, 1'b0);
      tick();
    end
    check("ld_4th_valid", rd_valid, 1'b1);
    rd_ready = 1'b1;
    tick();
    check("ld_hs_valid", rd_valid, 1'b0);
    check("ld_hs_ready", ins_ready, 1'b1);
    check("ld_hs_cnt", dut.rd_cnt, 1);
    done_rd(1);
    check("ld_done_cnt", dut.rd_cnt, 0);

    // Fill to the outstanding limit; the next load must wait for a completion.
    for (int i = 0; i < 15; i++) load_hs(4'h0);
    check("full_cnt", dut.rd_cnt, 15);
    send(mk_xfer(2'b00, 4'h1, 6'd2, 8'h01, 32'h0000_0040));
    check("full_hold_valid", rd_valid, 1'b0);
    check("full_hold_ready", ins_ready, 1'b0);
    tick();
    check("full_hold_valid2", rd_valid, 1'b0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("full_release", rd_valid, 1'b1);
    tick();
    check("full_hs_valid", rd_valid, 1'b0);
    check("full_hs_cnt", dut.rd_cnt, 15);
    done_rd(15);
    check("drain_cnt", dut.rd_cnt, 0);
    done_rd(1);
    check("no_underflow", dut.rd_cnt, 0);

    // Issue coincident with completion at count 3.
    for (int i = 0; i < 3; i++) load_hs(4'h5);
    send(mk_xfer(2'b00, 4'h6, 6'd3, 8'h02, 32'h0000_0080));
    check("coinc_valid", rd_valid, 1'b1);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("coinc_cnt", dut.rd_cnt, 3);
    done_rd(3);
    check("coinc_drain", dut.rd_cnt, 0);

    // Save stalled one cycle.
    send(mk_xfer(2'b01, 4'b0010, 6'd9, 8'h10, 32'hDEAD_BEEF));
    check("sv_fields", {wr_valid, wr_op, wr_buf_id, wr_size, wr_addr}, {1'b1, 4'h2, 6'd9, 8'h10, 32'hDEAD_BEEF});
    check("sv_rd_idle", rd_valid, 1'b0);
    tick();
    check("sv_stall_valid", wr_valid, 1'b1);
    wr_ready = 1'b1;
    tick();
    check("sv_hs_valid", wr_valid, 1'b0);
    check("sv_hs_cnt", dut.wr_cnt, 1);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("sv_done_cnt", dut.wr_cnt, 0);

    // Barrier with nothing outstanding: one cycle in SYNC.
    send(BAR);
    check("bar0_wait", sync_done, 1'b0);
    check("bar0_ready", ins_ready, 1'b0);
    tick();
    check("bar0_done", sync_done, 1'b1);
    check("bar0_exit_ready", ins_ready, 1'b1);
    tick();
    check("bar0_pulse_end", sync_done, 1'b0);

    // Two loads, one save, then a barrier released by late completions.
    load_hs(4'h7);
    load_hs(4'h8);
    send(mk_xfer(2'b01, 4'h3, 6'd4, 8'h20, 32'h0000_2000));
    check("bar_sv_valid", wr_valid, 1'b1);
    tick();
    send(BAR);
    for (int i = 0; i < 10; i++) begin
      check("bar_early", {sync_done, ins_ready}, 2'b00);
      tick();
    end
    rd_done = 1'b1; wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("bar_partial", sync_done, 1'b0);
    tick();
    rd_done = 1'b0;
    check("bar_done", sync_done, 1'b1);
    check("bar_ready", ins_ready, 1'b1);
    ins = CFG_A; ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
    check("bar_pulse_end", sync_done, 1'b0);
    check("bar_next_cfg", cfg_valid, 1'b1);

    // Load with opcode 0011.
    send(mk_xfer(2'b00, 4'b0011, 6'd7, 8'h04, 32'h0000_0100));
`ifdef INS_OPCODE_CHECK_EN
    check("badop_err", err, 1'b1);
    check("badop_no_valid", rd_valid, 1'b0);
    check("badop_ready", ins_ready, 1'b1);
    ins = CFG_B; ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
    check("badop_next", cfg_valid, 1'b1);
    check("badop_sticky", err, 1'b1);
`else
    check("op3_valid", rd_valid, 1'b1);
    check("op3_op", rd_op, 4'h3);
    check("op3_err", err, 1'b0);
    tick();
    done_rd(1);
    check("op3_cnt", dut.rd_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
